// File: rtl/clct_pass_sequencer.sv
// Two-pass CLCT selector: picks the best key window, blanks its neighbourhood,
// then picks the second-best window and reports both against a threshold.
module clct_pass_sequencer #(
    parameter int NWIN     = 16,
    parameter int PRI_BITS = 4
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic [NWIN*PRI_BITS-1:0] win_pri,
    input  logic [1:0]               blank_width,
    input  logic [PRI_BITS-1:0]      pri_thresh,
    output logic                     busy,
    output logic                     done,
    output logic                     overrun,
    output logic                     clct0_vld,
    output logic [$clog2(NWIN)-1:0]  clct0_win,
    output logic [PRI_BITS-1:0]      clct0_pri,
    output logic                     clct1_vld,
    output logic [$clog2(NWIN)-1:0]  clct1_win,
    output logic [PRI_BITS-1:0]      clct1_pri
);

    localparam int WB = $clog2(NWIN);

    typedef enum logic [2:0] {
        IDLE,
        PASS1,
        BLANK,
        PASS2,
        DONE
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic                  accept;

    logic [PRI_BITS-1:0]   pri_q [NWIN];
    logic [1:0]            bw_q;
    logic [PRI_BITS-1:0]   thresh_q;
    logic [WB-1:0]         best0_win_q;
    logic [PRI_BITS-1:0]   best0_pri_q;
    logic                  overrun_q;

    logic [WB-1:0]         sel_win;
    logic [PRI_BITS-1:0]   sel_pri;
    logic [NWIN-1:0]       blank_mask;
    logic                  vld0;
    logic                  vld1;

    // Strict '>' while scanning upward keeps the lowest index on ties.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        sel_win = '0;
        sel_pri = '0;
        for (int i = 0; i < NWIN; i++) begin
            if (pri_q[i] > sel_pri) begin
                sel_pri = pri_q[i];
                sel_win = WB'(i);
            end
        end
    end

    // Signed int bounds give the clamp at both ends for free: no index wraps.
    always_comb begin
        blank_mask = '0;
        for (int i = 0; i < NWIN; i++) begin
            blank_mask[i] = (i >= int'(best0_win_q) - int'(bw_q)) &&
                            (i <= int'(best0_win_q) + int'(bw_q));
        end
    end

    assign vld0 = (best0_pri_q != '0) && (best0_pri_q >= thresh_q);
    assign vld1 = vld0 && (sel_pri != '0) && (sel_pri >= thresh_q);

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = PASS1;
                end else begin
                    state_d = IDLE;
                end
            end
            PASS1:   state_d = BLANK;
            BLANK:   state_d = PASS2;
            PASS2:   state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    assign busy    = (state_q == PASS1) || (state_q == BLANK) || (state_q == PASS2);
    assign done    = (state_q == DONE);
    assign overrun = overrun_q;

    always_ff @(posedge clock or negedge reset_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!reset_n) begin
            state_q   <= IDLE;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            overrun_q <= start && busy;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: the priority array is reset too, so an aborted request leaves nothing behind.
            for (int i = 0; i < NWIN; i++) begin
                pri_q[i] <= '0;
            end
            bw_q        <= '0;
            thresh_q    <= '0;
            best0_win_q <= '0;
            best0_pri_q <= '0;
            clct0_vld   <= 1'b0;
            clct0_win   <= '0;
            clct0_pri   <= '0;
            clct1_vld   <= 1'b0;
            clct1_win   <= '0;
            clct1_pri   <= '0;
        end else begin
            if (accept) begin
                for (int i = 0; i < NWIN; i++) begin
                    pri_q[i] <= win_pri[PRI_BITS*i +: PRI_BITS];
                end
                bw_q     <= blank_width;
                thresh_q <= pri_thresh;
            end
            if (state_q == PASS1) begin
                best0_win_q <= sel_win;
                best0_pri_q <= sel_pri;
            end
            if (state_q == BLANK) begin
                for (int i = 0; i < NWIN; i++) begin
                    if (blank_mask[i]) begin
                        pri_q[i] <= '0;
                    end
                end
            end
            // PASS2 scans the blanked array; both results land together on DONE entry.
            if (state_q == PASS2) begin
                clct0_vld <= vld0;
                clct0_win <= vld0 ? best0_win_q : '0;
                clct0_pri <= vld0 ? best0_pri_q : '0;
                clct1_vld <= vld1;
                clct1_win <= vld1 ? sel_win : '0;
                clct1_pri <= vld1 ? sel_pri : '0;
            end
        end
    end

endmodule
